// File: rtl/mag_mon_pkg.sv
// Shared types and constants for the magnitude window monitor.
package mag_mon_pkg;

    localparam int unsigned DefWidth   = 8;
    localparam int unsigned DefWinLog2 = 2;
    localparam int unsigned DefHold    = 3;

    // Alarm FSM states
    typedef enum logic [2:0] {
        StFill,
        StNormal,
        StPendHi,
        StAlarm,
        StPendLo
    } mon_state_e;

    // Running sum must hold 2^win_log2 full-scale samples without overflow
    function automatic int unsigned sum_width(input int unsigned width,
                                              input int unsigned win_log2);
        return width + win_log2;
    endfunction

endpackage

// File: rtl/mag_avg_window.sv
// Power-of-two moving average over the last 2^WIN_LOG2 accepted samples.
// avg_valid pulses one cycle after each sample once the window is full.
module mag_avg_window
    import mag_mon_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned WIN_LOG2 = DefWinLog2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] sample,
    input  logic             sample_valid,
    output logic [WIDTH-1:0] avg_out,
    output logic             avg_valid
);

    localparam int unsigned Depth = 1 << WIN_LOG2;
    localparam int unsigned SumW  = sum_width(WIDTH, WIN_LOG2);
    localparam int unsigned FillW = WIN_LOG2 + 1;
    localparam logic [FillW-1:0] FillFull = FillW'(Depth);

    // win_q[0] is the newest sample, win_q[Depth-1] the oldest
    logic [WIDTH-1:0] win_q [Depth];
    logic [WIDTH-1:0] win_d [Depth];
    logic [SumW-1:0]  sum_q, sum_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] avg_q, avg_d;
    logic             avg_valid_q, avg_valid_d;

    // Next-state: shift window, update running sum, schedule the average
    always_comb begin
        win_d       = win_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        pend_d      = 1'b0;
        avg_d       = avg_q;
        avg_valid_d = pend_q;

        // sum_q already includes the sample accepted last cycle
        if (pend_q) begin
            avg_d = WIDTH'(sum_q >> WIN_LOG2);
        end

        if (sample_valid) begin
            for (int i = Depth - 1; i > 0; i--) begin
                win_d[i] = win_q[i-1];
            end
            win_d[0] = sample;
            // Oldest is still zero while filling, so the subtraction is harmless
            sum_d = sum_q + SumW'(sample) - SumW'(win_q[Depth-1]);
            if (fill_q != FillFull) begin
                fill_d = fill_q + FillW'(1);
            end
            pend_d = (fill_d == FillFull);
        end

        if (clear) begin
            for (int i = 0; i < Depth; i++) begin
                win_d[i] = '0;
            end
            sum_d       = '0;
            fill_d      = '0;
            pend_d      = 1'b0;
            avg_d       = '0;
            avg_valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                win_q[i] <= '0;
            end
            sum_q       <= '0;
            fill_q      <= '0;
            pend_q      <= 1'b0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            win_q       <= win_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            pend_q      <= pend_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    assign avg_out   = avg_q;
    assign avg_valid = avg_valid_q;

endmodule

// File: rtl/mag_window_monitor.sv
// Magnitude window monitor: moving average, peak, sample count and a
// debounced hysteretic alarm on the average.
// Optional feature macro MAG_MIN_TRACK_EN adds a running minimum (min_out).
module mag_window_monitor
    import mag_mon_pkg::*;
#(
    parameter int unsigned WIDTH    = DefWidth,
    parameter int unsigned WIN_LOG2 = DefWinLog2,
    parameter int unsigned HOLD     = DefHold
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] mag_in,
    input  logic             mag_valid,
    input  logic             clear,
    input  logic [WIDTH-1:0] thr_hi,
    input  logic [WIDTH-1:0] thr_lo,
    output logic [WIDTH-1:0] avg_out,
    output logic             avg_valid,
    output logic [WIDTH-1:0] peak_out,
    output logic             alarm,
    output logic             alarm_rise,
    output logic [15:0]      sample_cnt
`ifdef MAG_MIN_TRACK_EN
    ,
    output logic [WIDTH-1:0] min_out
`endif
);

    localparam logic [3:0] HoldCnt = 4'(HOLD);

    // clear wins over a coincident sample
    logic accept;
    assign accept = mag_valid & ~clear;

    mag_avg_window #(
        .WIDTH    (WIDTH),
        .WIN_LOG2 (WIN_LOG2)
    ) u_avg (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .sample       (mag_in),
        .sample_valid (accept),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid)
    );

    mon_state_e       state_q, state_d, eval_state;
    logic [3:0]       hold_q, hold_d, hold_inc;
    logic             alarm_q, alarm_d;
    logic             rise_q, rise_d;
    logic [WIDTH-1:0] thr_lo_eff;
    logic             is_hi, is_lo;
    logic [WIDTH-1:0] peak_q, peak_d;
    logic [15:0]      cnt_q, cnt_d;

    assign thr_lo_eff = (thr_lo < thr_hi) ? thr_lo : thr_hi;
    assign is_hi      = (avg_out >= thr_hi);
    assign is_lo      = (avg_out < thr_lo_eff);
    assign hold_inc   = hold_q + 4'd1;
    // The first average out of FILL is judged as if already in NORMAL
    assign eval_state = (state_q == StFill) ? StNormal : state_q;

    // Alarm FSM next-state; steps only on a fresh average
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;

        if (avg_valid) begin
            state_d = eval_state;
            unique case (eval_state)
                StNormal: begin
                    if (is_hi) begin
                        if (HOLD == 1) begin
                            state_d = StAlarm;
                            hold_d  = '0;
                        end else begin
                            state_d = StPendHi;
                            hold_d  = 4'd1;
                        end
                    end
                end
                StPendHi: begin
                    if (!is_hi) begin
                        state_d = StNormal;
                        hold_d  = '0;
                    end else if (hold_inc == HoldCnt) begin
                        state_d = StAlarm;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
                StAlarm: begin
                    if (is_lo) begin
                        if (HOLD == 1) begin
                            state_d = StNormal;
                            hold_d  = '0;
                        end else begin
                            state_d = StPendLo;
                            hold_d  = 4'd1;
                        end
                    end
                end
                StPendLo: begin
                    if (!is_lo) begin
                        state_d = StAlarm;
                        hold_d  = '0;
                    end else if (hold_inc == HoldCnt) begin
                        state_d = StNormal;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_inc;
                    end
                end
                default: begin
                    state_d = StNormal;
                    hold_d  = '0;
                end
            endcase
        end

        alarm_d = (state_d == StAlarm) || (state_d == StPendLo);
        rise_d  = alarm_d & ~alarm_q;

        if (clear) begin
            state_d = StFill;
            hold_d  = '0;
            alarm_d = 1'b0;
            rise_d  = 1'b0;
        end
    end

    // Peak and saturating sample counter next-state
    always_comb begin
        peak_d = peak_q;
        cnt_d  = cnt_q;
        if (accept) begin
            if (mag_in > peak_q) begin
                peak_d = mag_in;
            end
            if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        if (clear) begin
            peak_d = '0;
            cnt_d  = '0;
        end
    end

    // FSM, alarm, peak and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
            hold_q  <= '0;
            alarm_q <= 1'b0;
            rise_q  <= 1'b0;
            peak_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            alarm_q <= alarm_d;
            rise_q  <= rise_d;
            peak_q  <= peak_d;
            cnt_q   <= cnt_d;
        end
    end

    assign peak_out   = peak_q;
    assign alarm      = alarm_q;
    assign alarm_rise = rise_q;
    assign sample_cnt = cnt_q;

`ifdef MAG_MIN_TRACK_EN
    logic [WIDTH-1:0] min_q, min_d;

    // Running minimum next-state; idles at all-ones until a sample arrives
    always_comb begin
        min_d = min_q;
        if (accept && (mag_in < min_q)) begin
            min_d = mag_in;
        end
        if (clear) begin
            min_d = '1;
        end
    end

    // Running minimum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= '1;
        end else begin
            min_q <= min_d;
        end
    end

    assign min_out = min_q;
`else
    // Minimum tracking not built in this configuration
`endif

endmodule

// File: tb/tb_mag_window_monitor.sv
// Scoreboard bench for mag_window_monitor (default parameters).
module tb_mag_window_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  mag_in;
    logic        mag_valid;
    logic        clear;
    logic [7:0]  thr_hi;
    logic [7:0]  thr_lo;
    logic [7:0]  avg_out;
    logic        avg_valid;
    logic [7:0]  peak_out;
    logic        alarm;
    logic        alarm_rise;
    logic [15:0] sample_cnt;
`ifdef MAG_MIN_TRACK_EN
    logic [7:0]  min_out;
`endif

    mag_window_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mag_in     (mag_in),
        .mag_valid  (mag_valid),
        .clear      (clear),
        .thr_hi     (thr_hi),
        .thr_lo     (thr_lo),
        .avg_out    (avg_out),
        .avg_valid  (avg_valid),
        .peak_out   (peak_out),
        .alarm      (alarm),
        .alarm_rise (alarm_rise),
        .sample_cnt (sample_cnt)
`ifdef MAG_MIN_TRACK_EN
        ,
        .min_out    (min_out)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] avg;
        logic       alm;
        logic       rise;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic alm_pend = 1'b0;
    exp_t held;
    exp_t popped;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one sample for one edge; queue its average when one is due
    task automatic send(input logic [7:0] v, input bit has_avg, input logic [7:0] a,
                        input logic al, input logic ri);
        exp_t e;
        mag_in    = v;
        mag_valid = 1'b1;
        if (has_avg) begin
            e.avg  = a;
            e.alm  = al;
            e.rise = ri;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        mag_valid = 1'b0;
    endtask

    task automatic s0(input logic [7:0] v);
        send(v, 1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic sa(input logic [7:0] v, input logic [7:0] a, input logic al, input logic ri);
        send(v, 1'b1, a, al, ri);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Monitor: pops on every avg_valid, checks alarm the following cycle
    initial begin
        forever begin
            @(negedge clk);
            if (alm_pend) begin
                check("alarm", {15'd0, alarm}, {15'd0, held.alm});
                check("alarm_rise", {15'd0, alarm_rise}, {15'd0, held.rise});
                alm_pend = 1'b0;
            end
            if (rst_n === 1'b1 && avg_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_avg_valid: got pulse avg_out=%0d, required none (t=%0t)",
                             avg_out, $time);
                end else begin
                    popped = exp_q.pop_front();
                    check("avg_out", {8'd0, avg_out}, {8'd0, popped.avg});
                    held     = popped;
                    alm_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b1;
        mag_in    = '0;
        mag_valid = 1'b0;
        clear     = 1'b0;
        thr_hi    = 8'd255;
        thr_lo    = 8'd0;
        #2;
        rst_n = 1'b0;
        #10;
        check("rst_avg_out", {8'd0, avg_out}, 16'd0);
        check("rst_avg_valid", {15'd0, avg_valid}, 16'd0);
        check("rst_peak", {8'd0, peak_out}, 16'd0);
        check("rst_alarm", {15'd0, alarm}, 16'd0);
        check("rst_alarm_rise", {15'd0, alarm_rise}, 16'd0);
        check("rst_sample_cnt", sample_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // Fill, first average and window slide
        s0(8'd10);
        s0(8'd20);
        s0(8'd30);
        sa(8'd40, 8'd25, 1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        check("t1_peak", {8'd0, peak_out}, 16'd40);
        check("t1_cnt", sample_cnt, 16'd4);
        sa(8'd100, 8'd47, 1'b0, 1'b0);
        sa(8'd0, 8'd42, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        check("t2_peak", {8'd0, peak_out}, 16'd100);
        check("t2_cnt", sample_cnt, 16'd6);

        // Alarm entry with HOLD=3
        thr_hi = 8'd50;
        thr_lo = 8'd30;
        do_clear();
        s0(8'd60);
        s0(8'd60);
        s0(8'd60);
        sa(8'd60, 8'd60, 1'b0, 1'b0);
        sa(8'd60, 8'd60, 1'b0, 1'b0);
        sa(8'd60, 8'd60, 1'b1, 1'b1);
        sa(8'd60, 8'd60, 1'b1, 1'b0);
        sa(8'd60, 8'd60, 1'b1, 1'b0);

        // Alarm release: 30 is not lo, then three lo averages
        sa(8'd40, 8'd55, 1'b1, 1'b0);
        sa(8'd40, 8'd50, 1'b1, 1'b0);
        sa(8'd40, 8'd45, 1'b1, 1'b0);
        sa(8'd40, 8'd40, 1'b1, 1'b0);
        sa(8'd0, 8'd30, 1'b1, 1'b0);
        sa(8'd0, 8'd20, 1'b1, 1'b0);
        sa(8'd0, 8'd10, 1'b1, 1'b0);
        sa(8'd0, 8'd0, 1'b0, 1'b0);

        // Re-arm, then PEND_LO interrupted by an average of 30
        sa(8'd60, 8'd15, 1'b0, 1'b0);
        sa(8'd60, 8'd30, 1'b0, 1'b0);
        sa(8'd60, 8'd45, 1'b0, 1'b0);
        sa(8'd60, 8'd60, 1'b0, 1'b0);
        sa(8'd60, 8'd60, 1'b0, 1'b0);
        sa(8'd60, 8'd60, 1'b1, 1'b1);
        sa(8'd0, 8'd45, 1'b1, 1'b0);
        sa(8'd0, 8'd30, 1'b1, 1'b0);
        sa(8'd0, 8'd15, 1'b1, 1'b0);
        sa(8'd120, 8'd30, 1'b1, 1'b0);
        sa(8'd0, 8'd30, 1'b1, 1'b0);
        sa(8'd0, 8'd30, 1'b1, 1'b0);
        sa(8'd0, 8'd30, 1'b1, 1'b0);
        sa(8'd0, 8'd0, 1'b1, 1'b0);
        sa(8'd0, 8'd0, 1'b1, 1'b0);
        sa(8'd0, 8'd0, 1'b0, 1'b0);
        idle(2);

        // thr_lo above thr_hi: release threshold falls back to thr_hi
        thr_lo = 8'd200;
        do_clear();
        s0(8'd60);
        s0(8'd60);
        s0(8'd60);
        sa(8'd60, 8'd60, 1'b0, 1'b0);
        sa(8'd60, 8'd60, 1'b0, 1'b0);
        sa(8'd60, 8'd60, 1'b1, 1'b1);
        sa(8'd40, 8'd55, 1'b1, 1'b0);
        sa(8'd40, 8'd50, 1'b1, 1'b0);
        sa(8'd40, 8'd45, 1'b1, 1'b0);
        sa(8'd40, 8'd40, 1'b1, 1'b0);
        sa(8'd40, 8'd40, 1'b0, 1'b0);
        idle(2);
        thr_lo = 8'd30;

        // clear beats a coincident sample
        do_clear();
        s0(8'd200);
        s0(8'd5);
        @(negedge clk);
        check("t5_peak_pre", {8'd0, peak_out}, 16'd200);
        check("t5_cnt_pre", sample_cnt, 16'd2);
        mag_in    = 8'd250;
        mag_valid = 1'b1;
        clear     = 1'b1;
        @(posedge clk);
        #1;
        clear     = 1'b0;
        mag_valid = 1'b0;
        @(negedge clk);
        check("t5_peak", {8'd0, peak_out}, 16'd0);
        check("t5_cnt", sample_cnt, 16'd0);
        check("t5_avg_out", {8'd0, avg_out}, 16'd0);
        check("t5_alarm", {15'd0, alarm}, 16'd0);
        s0(8'd8);
        s0(8'd8);
        s0(8'd8);
        sa(8'd8, 8'd8, 1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        check("t5_peak_post", {8'd0, peak_out}, 16'd8);
        check("t5_cnt_post", sample_cnt, 16'd4);

        // Async reset while in alarm with history
        do_clear();
        s0(8'd60);
        s0(8'd60);
        s0(8'd60);
        sa(8'd60, 8'd60, 1'b0, 1'b0);
        sa(8'd60, 8'd60, 1'b0, 1'b0);
        sa(8'd60, 8'd60, 1'b1, 1'b1);
        sa(8'd70, 8'd62, 1'b1, 1'b0);
        sa(8'd70, 8'd65, 1'b1, 1'b0);
        idle(2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_avg_out", {8'd0, avg_out}, 16'd0);
        check("t6_avg_valid", {15'd0, avg_valid}, 16'd0);
        check("t6_peak", {8'd0, peak_out}, 16'd0);
        check("t6_alarm", {15'd0, alarm}, 16'd0);
        check("t6_alarm_rise", {15'd0, alarm_rise}, 16'd0);
        check("t6_cnt", sample_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        s0(8'd9);
        s0(8'd3);
        s0(8'd7);
`ifdef MAG_MIN_TRACK_EN
        @(negedge clk);
        check("t6_min", {8'd0, min_out}, 16'd3);
`endif
        sa(8'd1, 8'd5, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        check("t6_peak_post", {8'd0, peak_out}, 16'd9);
        check("t6_cnt_post", sample_cnt, 16'd4);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
